// File: rtl/aia_src_gateway.sv
// Per-source APLIC interrupt gateway: source-mode rectification, edge/level detection and pending bits.
// Define AIA_SRC_GATEWAY_SYNC_EN to place a SYNC_STAGES-deep synchronizer in front of every source.
module aia_src_gateway #(
   parameter int unsigned NR_SRC      = 32,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [NR_SRC-1:0]     src_i,
   input  logic [3*NR_SRC-1:0]   mode_i,
   input  logic [NR_SRC-1:0]     setip_i,
   input  logic [NR_SRC-1:0]     clrip_i,
   input  logic [NR_SRC-1:0]     claim_i,
   output logic [NR_SRC-1:0]     pend_o,
   output logic [NR_SRC-1:0]     rect_o
);

   localparam logic [2:0] SM_INACTIVE = 3'd0;
   localparam logic [2:0] SM_DETACHED = 3'd1;
   localparam logic [2:0] SM_EDGE1    = 3'd4;
   localparam logic [2:0] SM_EDGE0    = 3'd5;
   localparam logic [2:0] SM_LEVEL1   = 3'd6;
   localparam logic [2:0] SM_LEVEL0   = 3'd7;

   if (NR_SRC < 1 || NR_SRC > 1023 || SYNC_STAGES < 2) begin : g_param_check
      $error("aia_src_gateway: NR_SRC must be 1..1023 and SYNC_STAGES at least 2");
   end

   genvar gi;
   generate
      for (gi = 0; gi < NR_SRC; gi++) begin : g_src
         logic       s;
         logic [2:0] mode;
         logic [2:0] mode_reg;
         logic       prev_reg;
         logic       pend_reg;
         logic       rect_reg;
         logic       r;
         logic       pend_next;
         logic       clr;

`ifdef AIA_SRC_GATEWAY_SYNC_EN
         logic [SYNC_STAGES-1:0] sync_reg;

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               sync_reg <= '0;
            end else begin
               sync_reg <= {sync_reg[SYNC_STAGES-2:0], src_i[gi]};
            end
         end

         assign s = sync_reg[SYNC_STAGES-1];
`else
         assign s = src_i[gi];
`endif

         assign mode = mode_i[3*gi +: 3];
         assign clr  = clrip_i[gi] | claim_i[gi];

         always_comb begin
            r = 1'b0;
            case (mode)
               SM_EDGE1, SM_LEVEL1: r = s;
               SM_EDGE0, SM_LEVEL0: r = ~s;
               default:             r = 1'b0;
            endcase
         end

         // A mode change drops pending and re-baselines prev_reg under the new mode,
         // so switching into an edge mode while the wire is active never fakes an edge.
         always_comb begin
            pend_next = pend_reg;
            if (mode != mode_reg) begin
               pend_next = 1'b0;
            end else begin
               case (mode)
                  SM_DETACHED: begin
                     if (setip_i[gi])  pend_next = 1'b1;
                     else if (clr)     pend_next = 1'b0;
                  end
                  SM_EDGE1, SM_EDGE0: begin
                     if ((r & ~prev_reg) | setip_i[gi]) pend_next = 1'b1;
                     else if (clr)                      pend_next = 1'b0;
                  end
                  SM_LEVEL1, SM_LEVEL0: begin
                     if (r)            pend_next = 1'b1;
                     else if (clr)     pend_next = 1'b0;
                  end
                  default:             pend_next = 1'b0;
               endcase
            end
         end

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               mode_reg <= SM_INACTIVE;
               prev_reg <= 1'b0;
               pend_reg <= 1'b0;
               rect_reg <= 1'b0;
            end else begin
               mode_reg <= mode;
               prev_reg <= r;
               pend_reg <= pend_next;
               rect_reg <= r;
            end
         end

         assign pend_o[gi] = pend_reg;
         assign rect_o[gi] = rect_reg;
      end
   endgenerate

endmodule

// File: tb/tb_aia_src_gateway.sv
// Directed scoreboard bench for aia_src_gateway with four sources and the synchronizer compiled out.
module tb_aia_src_gateway;

   localparam int NR = 4;

   logic            clk;
   logic            rst;
   logic [NR-1:0]   src;
   logic [3*NR-1:0] mode;
   logic [NR-1:0]   setip;
   logic [NR-1:0]   clrip;
   logic [NR-1:0]   claim;
   logic [NR-1:0]   pend;
   logic [NR-1:0]   rect;

   typedef struct {
      string         tag;
      logic [NR-1:0] pmask;
      logic [NR-1:0] pval;
      logic [NR-1:0] rmask;
      logic [NR-1:0] rval;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   aia_src_gateway #(.NR_SRC(NR), .SYNC_STAGES(2)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .src_i   (src),
      .mode_i  (mode),
      .setip_i (setip),
      .clrip_i (clrip),
      .claim_i (claim),
      .pend_o  (pend),
      .rect_o  (rect)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic expect_out(input string tag, input logic [NR-1:0] pm, input logic [NR-1:0] pv,
                             input logic [NR-1:0] rm, input logic [NR-1:0] rv);
      exp_t e;
      e.tag = tag; e.pmask = pm; e.pval = pv; e.rmask = rm; e.rval = rv;
      sb.push_back(e);
   endtask

   task automatic set_mode(input int k, input logic [2:0] m);
      mode[3*k +: 3] = m;
   endtask

   // Advance one clock, then compare everything queued for this edge.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         assert ((pend & e.pmask) === e.pval)
         else begin
            errors++;
            $error("FAIL %s pend_o=%b expected %b (mask %b)", e.tag, pend & e.pmask, e.pval, e.pmask);
         end
         if (e.rmask != '0) begin
            checks++;
            assert ((rect & e.rmask) === e.rval)
            else begin
               errors++;
               $error("FAIL %s rect_o=%b expected %b (mask %b)", e.tag, rect & e.rmask, e.rval, e.rmask);
            end
         end
         $display("[%0t] %s pend_o=%b rect_o=%b", $time, e.tag, pend, rect);
      end
   endtask

   initial begin
      rst = 1'b1; src = '0; mode = '0; setip = '0; clrip = '0; claim = '0;
      expect_out("reset", 4'hF, 4'h0, 4'hF, 4'h0);
      tick();
      rst = 1'b0;

      // ch0 Edge1, ch1 Edge0, ch2 Level1, ch3 Inactive
      set_mode(0, 3'd4); set_mode(1, 3'd5); set_mode(2, 3'd6); set_mode(3, 3'd0);
      expect_out("mode_init", 4'hF, 4'h0, 4'hF, 4'b0010);
      tick();
      expect_out("mode_settled", 4'hF, 4'h0, 4'h0, 4'h0);
      tick();

      // Edge1 on ch0
      src[0] = 1'b1;
      expect_out("edge1_rise", 4'b0001, 4'b0001, 4'b0001, 4'b0001);
      tick();
      expect_out("edge1_hold1", 4'b0001, 4'b0001, 4'h0, 4'h0);
      tick();
      expect_out("edge1_hold2", 4'b0001, 4'b0001, 4'h0, 4'h0);
      tick();
      claim[0] = 1'b1;
      expect_out("edge1_claim", 4'b0001, 4'b0000, 4'h0, 4'h0);
      tick();
      claim[0] = 1'b0;
      expect_out("edge1_no_retrig", 4'b0001, 4'b0000, 4'b0001, 4'b0001);
      tick();
      setip[0] = 1'b1;
      expect_out("edge1_setip", 4'b0001, 4'b0001, 4'h0, 4'h0);
      tick();

      // Reserved mode on ch0 while setip held: pending dropped, rect forced 0
      set_mode(0, 3'd2);
      expect_out("reserved_switch", 4'b0001, 4'b0000, 4'b0001, 4'b0000);
      tick();
      expect_out("reserved_setip", 4'b0001, 4'b0000, 4'b0001, 4'b0000);
      tick();
      setip[0] = 1'b0;

      // Edge0 on ch1 with simultaneous claim
      src[1] = 1'b1;
      expect_out("edge0_high", 4'b0010, 4'b0000, 4'b0010, 4'b0000);
      tick();
      src[1] = 1'b0;
      expect_out("edge0_fall", 4'b0010, 4'b0010, 4'b0010, 4'b0010);
      tick();
      src[1] = 1'b1;
      expect_out("edge0_rehigh", 4'b0010, 4'b0010, 4'h0, 4'h0);
      tick();
      src[1] = 1'b0; claim[1] = 1'b1;
      expect_out("edge0_fall_claim", 4'b0010, 4'b0010, 4'h0, 4'h0);
      tick();
      expect_out("edge0_claim", 4'b0010, 4'b0000, 4'h0, 4'h0);
      tick();
      claim[1] = 1'b0;

      // Level1 on ch2
      src[2] = 1'b1;
      expect_out("level_assert", 4'b0100, 4'b0100, 4'b0100, 4'b0100);
      tick();
      clrip[2] = 1'b1;
      expect_out("level_clr_blocked", 4'b0100, 4'b0100, 4'h0, 4'h0);
      tick();
      clrip[2] = 1'b0; src[2] = 1'b0;
      expect_out("level_deassert", 4'b0100, 4'b0100, 4'b0100, 4'b0000);
      tick();
      clrip[2] = 1'b1;
      expect_out("level_clr", 4'b0100, 4'b0000, 4'h0, 4'h0);
      tick();
      clrip[2] = 1'b0; setip[2] = 1'b1;
      expect_out("level_setip_ignored", 4'b0100, 4'b0000, 4'h0, 4'h0);
      tick();
      setip[2] = 1'b0;

      // Mode switch on ch3 with wire already high
      src[3] = 1'b1;
      expect_out("inactive_high", 4'b1000, 4'b0000, 4'b1000, 4'b0000);
      tick();
      set_mode(3, 3'd4);
      for (int i = 0; i < 5; i++) begin
         expect_out($sformatf("switch_edge1_%0d", i), 4'b1000, 4'b0000, 4'b1000, 4'b1000);
         tick();
      end
      set_mode(3, 3'd1); setip[3] = 1'b1;
      expect_out("switch_detached_strobe_ignored", 4'b1000, 4'b0000, 4'b1000, 4'b0000);
      tick();
      expect_out("detached_setip", 4'b1000, 4'b1000, 4'h0, 4'h0);
      tick();
      setip[3] = 1'b0; clrip[3] = 1'b1;
      expect_out("detached_clrip", 4'b1000, 4'b0000, 4'h0, 4'h0);
      tick();
      setip[3] = 1'b1;
      expect_out("detached_set_wins", 4'b1000, 4'b1000, 4'h0, 4'h0);
      tick();
      setip[3] = 1'b0; clrip[3] = 1'b0; claim[3] = 1'b1;
      expect_out("detached_claim", 4'b1000, 4'b0000, 4'h0, 4'h0);
      tick();
      claim[3] = 1'b0;

      // Reset mid-operation with a Level1 source asserted
      src[2] = 1'b1;
      expect_out("pre_reset_level", 4'hF, 4'b0100, 4'h0, 4'h0);
      tick();
      rst = 1'b1;
      expect_out("mid_reset", 4'hF, 4'h0, 4'hF, 4'h0);
      tick();
      rst = 1'b0;
      expect_out("post_reset_mode_reload", 4'hF, 4'h0, 4'hF, 4'b0110);
      tick();
      expect_out("post_reset_level", 4'hF, 4'b0100, 4'h0, 4'h0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
